// File: rtl/cache_arbiter.sv
// Arbitrates one shared line-wide L2 port between icache reads and dcache allocates/write-backs.
// Dcache wins by default; a saturating starvation counter forces an icache grant.
module cache_arbiter #(
    parameter int s_line       = 256,
    parameter int starve_limit = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_pmem_read,
    input  logic [31:0]       i_pmem_addr,
    output logic [s_line-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [31:0]       d_pmem_addr,
    input  logic [s_line-1:0] d_pmem_wdata,
    output logic [s_line-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [31:0]       l2_addr,
    output logic [s_line-1:0] l2_wdata,
    input  logic [s_line-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic [31:0]       conflict_count,
    input  logic              conflict_reset
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    localparam logic [2:0] LIMIT = 3'(starve_limit);

    state_t            state_q, state_d;
    logic [2:0]        starve_q, starve_d;
    logic [31:0]       conflict_q, conflict_d;
    logic              l2_read_q, l2_read_d;
    logic              l2_write_q, l2_write_d;
    logic [31:0]       l2_addr_q, l2_addr_d;
    logic [s_line-1:0] l2_wdata_q, l2_wdata_d;

    logic i_req, d_req, grant_i, grant_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        conflict_d = conflict_q;
        l2_read_d  = l2_read_q;
        l2_write_d = l2_write_q;
        l2_addr_d  = l2_addr_q;
        l2_wdata_d = l2_wdata_q;
        grant_i    = 1'b0;
        grant_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (d_req && !(i_req && starve_q == LIMIT)) begin
                    grant_d = 1'b1;
                    state_d = SERVE_D;
                end else if (i_req) begin
                    grant_i = 1'b1;
                    state_d = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_resp) begin
                    state_d    = IDLE;
                    l2_read_d  = 1'b0;
                    l2_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A combined read+write request from the dcache is a write-back only.
        if (grant_d) begin
            l2_read_d  = d_pmem_read & ~d_pmem_write;
            l2_write_d = d_pmem_write;
            l2_addr_d  = d_pmem_addr;
            l2_wdata_d = d_pmem_wdata;
            if (i_req && starve_q != LIMIT)
                starve_d = starve_q + 3'd1;
        end else if (grant_i) begin
            l2_read_d  = 1'b1;
            l2_write_d = 1'b0;
            l2_addr_d  = i_pmem_addr;
            starve_d   = 3'd0;
        end

        if (conflict_reset)
            conflict_d = 32'd0;
        else if ((grant_i || grant_d) && i_req && d_req)
            conflict_d = conflict_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            starve_q   <= 3'd0;
            conflict_q <= 32'd0;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
            l2_addr_q  <= 32'd0;
            l2_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            conflict_q <= conflict_d;
            l2_read_q  <= l2_read_d;
            l2_write_q <= l2_write_d;
            l2_addr_q  <= l2_addr_d;
            l2_wdata_q <= l2_wdata_d;
        end
    end

    assign l2_read        = l2_read_q;
    assign l2_write       = l2_write_q;
    assign l2_addr        = l2_addr_q;
    assign l2_wdata       = l2_wdata_q;
    assign conflict_count = conflict_q;

    assign i_pmem_resp  = (state_q == SERVE_I) & l2_resp;
    assign d_pmem_resp  = (state_q == SERVE_D) & l2_resp;
    assign i_pmem_rdata = l2_rdata;
    assign d_pmem_rdata = l2_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: hand-computed expectations checked with immediate assertions.
module tb_cache_arbiter;

    localparam int SL = 256;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_pmem_read;
    logic [31:0]   i_pmem_addr;
    logic [SL-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [31:0]   d_pmem_addr;
    logic [SL-1:0] d_pmem_wdata;
    logic [SL-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          l2_read;
    logic          l2_write;
    logic [31:0]   l2_addr;
    logic [SL-1:0] l2_wdata;
    logic [SL-1:0] l2_rdata;
    logic          l2_resp;
    logic [31:0]   conflict_count;
    logic          conflict_reset;

    int errors = 0;
    int checks = 0;

    localparam logic [SL-1:0] LINE_A = {8{32'hA5A5_0001}};
    localparam logic [SL-1:0] LINE_B = {8{32'hBEEF_0002}};
    localparam logic [SL-1:0] LINE_C = {8{32'hC0DE_0003}};
    localparam logic [SL-1:0] LINE_D = {8{32'hD00D_0004}};

    cache_arbiter #(.s_line(SL), .starve_limit(4)) dut (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_pmem_read), .i_pmem_addr(i_pmem_addr),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_addr(d_pmem_addr), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .conflict_count(conflict_count), .conflict_reset(conflict_reset)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk256(input string tag, input logic [SL-1:0] obs, input logic [SL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse l2_resp for one cycle with the given data; caller checks the owner response.
    task automatic l2_pulse(input logic [SL-1:0] data);
        l2_rdata = data;
        l2_resp  = 1'b1;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        i_pmem_read = 1'b0; i_pmem_addr = 32'd0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        d_pmem_addr = 32'd0; d_pmem_wdata = '0;
        l2_rdata = '0; l2_resp = 1'b0; conflict_reset = 1'b0;

        step(); step();
        chk1("rst_l2_read", l2_read, 1'b0);
        chk1("rst_l2_write", l2_write, 1'b0);
        chk32("rst_l2_addr", l2_addr, 32'd0);
        chk256("rst_l2_wdata", l2_wdata, '0);
        chk32("rst_conflict", conflict_count, 32'd0);
        chk1("rst_i_resp", i_pmem_resp, 1'b0);
        chk1("rst_d_resp", d_pmem_resp, 1'b0);
        reset = 1'b0;
        step();

        // l2_resp while idle must do nothing
        l2_pulse(LINE_D);
        chk1("idle_resp_i", i_pmem_resp, 1'b0);
        chk1("idle_resp_d", d_pmem_resp, 1'b0);
        step();
        l2_resp = 1'b0;
        chk1("idle_resp_noread", l2_read, 1'b0);
        chk1("idle_resp_nowrite", l2_write, 1'b0);

        // Lone icache read
        i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_0060;
        step();
        chk1("t1_l2_read", l2_read, 1'b1);
        chk1("t1_l2_write", l2_write, 1'b0);
        chk32("t1_l2_addr", l2_addr, 32'h0000_0060);
        chk1("t1_i_resp_wait", i_pmem_resp, 1'b0);
        step(); step(); step();
        l2_pulse(LINE_A);
        chk1("t1_i_resp", i_pmem_resp, 1'b1);
        chk256("t1_i_rdata", i_pmem_rdata, LINE_A);
        chk1("t1_d_resp", d_pmem_resp, 1'b0);
        step();
        i_pmem_read = 1'b0; l2_resp = 1'b0;
        chk1("t1_done_read", l2_read, 1'b0);
        chk32("t1_conflict", conflict_count, 32'd0);
        step();

        // Simultaneous dcache write and icache read: dcache first
        d_pmem_write = 1'b1; d_pmem_addr = 32'h0000_1000; d_pmem_wdata = LINE_B;
        i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_0080;
        step();
        chk1("t2_d_write", l2_write, 1'b1);
        chk1("t2_d_read", l2_read, 1'b0);
        chk32("t2_d_addr", l2_addr, 32'h0000_1000);
        chk256("t2_d_wdata", l2_wdata, LINE_B);
        l2_pulse(LINE_C);
        chk1("t2_d_resp", d_pmem_resp, 1'b1);
        chk1("t2_i_noresp", i_pmem_resp, 1'b0);
        step();
        d_pmem_write = 1'b0; l2_resp = 1'b0;
        chk1("t2_gap_read", l2_read, 1'b0);
        chk1("t2_gap_write", l2_write, 1'b0);
        step();
        chk1("t2_i_read", l2_read, 1'b1);
        chk1("t2_i_write", l2_write, 1'b0);
        chk32("t2_i_addr", l2_addr, 32'h0000_0080);
        chk256("t2_wdata_kept", l2_wdata, LINE_B);
        chk32("t2_conflict", conflict_count, 32'd1);
        l2_pulse(LINE_A);
        chk1("t2_i_resp", i_pmem_resp, 1'b1);
        chk1("t2_d_noresp", d_pmem_resp, 1'b0);
        step();
        i_pmem_read = 1'b0; l2_resp = 1'b0;

        // Dcache streams while icache waits: 4 dcache grants, then icache
        conflict_reset = 1'b1;
        step();
        conflict_reset = 1'b0;
        chk32("t3_cleared", conflict_count, 32'd0);
        i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_0100;
        d_pmem_write = 1'b1; d_pmem_addr = 32'h0000_3000; d_pmem_wdata = LINE_C;
        for (int k = 0; k < 4; k++) begin
            step();
            chk1($sformatf("t3_dgrant%0d", k), l2_write, 1'b1);
            l2_pulse(LINE_D);
            chk1($sformatf("t3_dresp%0d", k), d_pmem_resp, 1'b1);
            step();
            l2_resp = 1'b0;
        end
        step();
        chk1("t3_igrant_read", l2_read, 1'b1);
        chk1("t3_igrant_write", l2_write, 1'b0);
        chk32("t3_igrant_addr", l2_addr, 32'h0000_0100);
        chk32("t3_conflict", conflict_count, 32'd5);
        l2_pulse(LINE_A);
        chk1("t3_i_resp", i_pmem_resp, 1'b1);
        step();
        i_pmem_read = 1'b0; d_pmem_write = 1'b0; l2_resp = 1'b0;
        step();

        // Read+write together is a write-back only
        d_pmem_read = 1'b1; d_pmem_write = 1'b1;
        d_pmem_addr = 32'h0000_2000; d_pmem_wdata = LINE_D;
        step();
        chk1("t4_write", l2_write, 1'b1);
        chk1("t4_read", l2_read, 1'b0);
        chk32("t4_addr", l2_addr, 32'h0000_2000);
        l2_pulse(LINE_A);
        step();
        d_pmem_read = 1'b0; d_pmem_write = 1'b0; l2_resp = 1'b0;
        chk32("t4_conflict", conflict_count, 32'd5);
        step();

        // Two more conflicts bring the count to 7
        for (int r = 0; r < 2; r++) begin
            d_pmem_read = 1'b1; d_pmem_addr = 32'h0000_4000;
            i_pmem_read = 1'b1; i_pmem_addr = 32'h0000_0140;
            step();
            chk1($sformatf("t5_alloc_read%0d", r), l2_read, 1'b1);
            chk1($sformatf("t5_alloc_write%0d", r), l2_write, 1'b0);
            l2_pulse(LINE_B);
            step();
            d_pmem_read = 1'b0; l2_resp = 1'b0;
            step();
            chk32($sformatf("t5_igrant_addr%0d", r), l2_addr, 32'h0000_0140);
            l2_pulse(LINE_B);
            step();
            i_pmem_read = 1'b0; l2_resp = 1'b0;
        end
        chk32("t5_conflict7", conflict_count, 32'd7);

        // conflict_reset beats the increment on a conflict grant
        d_pmem_read = 1'b1; d_pmem_addr = 32'h0000_4000;
        i_pmem_read = 1'b1;
        conflict_reset = 1'b1;
        step();
        conflict_reset = 1'b0;
        chk32("t5_conflict_clr", conflict_count, 32'd0);
        chk32("t5_dgrant_addr", l2_addr, 32'h0000_4000);
        chk1("t5_dgrant_read", l2_read, 1'b1);

        // Asynchronous reset while the dcache owns L2, then a late response
        step();
        reset = 1'b1;
        d_pmem_read = 1'b0; i_pmem_read = 1'b0;
        #1;
        chk1("t6_async_read", l2_read, 1'b0);
        chk1("t6_async_write", l2_write, 1'b0);
        chk32("t6_async_addr", l2_addr, 32'd0);
        chk256("t6_async_wdata", l2_wdata, '0);
        step();
        reset = 1'b0;
        l2_pulse(LINE_C);
        chk1("t6_late_d_resp", d_pmem_resp, 1'b0);
        chk1("t6_late_i_resp", i_pmem_resp, 1'b0);
        step();
        l2_resp = 1'b0;
        chk1("t6_after_read", l2_read, 1'b0);
        chk32("t6_after_conflict", conflict_count, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
